result_checker: RTL

- Avalon-MM slave on avalon_clock, directly downstream of the PLL-clocked test control unit.
- After a test run fills the pos and neg result RAMs, software starts this block. It sweeps an address window and reads both result RAMs and a golden RAM through their second ports.
- It compares masked data and reports per-side mismatch counts plus the first failing address, so software need not read back every word.

---
 rtl/result_checker.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/result_checker.sv
// result_checker: Avalon-MM slave that sweeps an address window over the pos/neg
// result RAMs and a golden RAM, counting masked mismatches per side.
module result_checker #(
  parameter int ID          = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int RAM_LATENCY = 2
) (
  input  logic                  avalon_clock,
  input  logic                  resetn,
  input  logic [2:0]            address,
  input  logic                  write,
  input  logic                  read,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [ADDR_WIDTH-1:0] chk_addr,
  input  logic [DATA_WIDTH-1:0] pos_data,
  input  logic [DATA_WIDTH-1:0] neg_data,
  input  logic [DATA_WIDTH-1:0] gold_data
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic [CW-1:0]         num_q, num_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [15:0]           err_pos_q, err_pos_d;
  logic [15:0]           err_neg_q, err_neg_d;
  logic                  first_valid_q, first_valid_d;
  logic                  first_pos_q, first_pos_d;
  logic                  first_neg_q, first_neg_d;
  logic [ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
  logic [ADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;
  logic [RAM_LATENCY-1:0] pv_q, pv_d;
  logic [ADDR_WIDTH-1:0] pa_q [RAM_LATENCY];
  logic [ADDR_WIDTH-1:0] pa_d [RAM_LATENCY];
  logic [31:0]           readdata_q, readdata_d;

  logic                  wr_ctrl_s, start_s, abort_s, busy_s, done_s;
  logic                  push_valid_s;
  logic [ADDR_WIDTH-1:0] push_addr_s;
  logic                  out_valid_s, mis_pos_s, mis_neg_s;
  logic                  unused_ok_s;

  assign wr_ctrl_s   = write && (address == 3'd0);
  assign abort_s     = wr_ctrl_s && writedata[1];
  assign start_s     = wr_ctrl_s && writedata[0];
  assign busy_s      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_s      = (state_q == ST_DONE);
  assign out_valid_s = pv_q[RAM_LATENCY-1];
  assign mis_pos_s   = |((pos_data ^ gold_data) & mask_q);
  assign mis_neg_s   = |((neg_data ^ gold_data) & mask_q);
  assign unused_ok_s = &{1'b0, writedata};

  // Sweep FSM, address pipeline, mismatch accounting and register file
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    start_addr_d  = start_addr_q;
    num_d         = num_q;
    mask_d        = mask_q;
    err_pos_d     = err_pos_q;
    err_neg_d     = err_neg_q;
    first_valid_d = first_valid_q;
    first_pos_d   = first_pos_q;
    first_neg_d   = first_neg_q;
    first_addr_d  = first_addr_q;
    chk_addr_d    = chk_addr_q;
    readdata_d    = readdata_q;
    push_valid_s  = 1'b0;
    push_addr_s   = cnt_q[ADDR_WIDTH-1:0];

    if (out_valid_s) begin
      if (mis_pos_s) err_pos_d = sat_inc(err_pos_q);
      else           err_pos_d = err_pos_q;
      if (mis_neg_s) err_neg_d = sat_inc(err_neg_q);
      else           err_neg_d = err_neg_q;
      if ((mis_pos_s || mis_neg_s) && !first_valid_q) begin
        first_valid_d = 1'b1;
        first_pos_d   = mis_pos_s;
        first_neg_d   = mis_neg_s;
        first_addr_d  = pa_q[RAM_LATENCY-1];
      end else begin
        first_valid_d = first_valid_q;
      end
    end else begin
      err_pos_d = err_pos_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (start_s) begin
          state_d       = ST_RUN;
          cnt_d         = {1'b0, start_addr_q};
          err_pos_d     = 16'd0;
          err_neg_d     = 16'd0;
          first_valid_d = 1'b0;
          first_pos_d   = 1'b0;
          first_neg_d   = 1'b0;
          first_addr_d  = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q < num_q) begin
          chk_addr_d   = cnt_q[ADDR_WIDTH-1:0];
          push_valid_s = 1'b1;
          cnt_d        = cnt_q + CW'(1);
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort_s)          state_d = ST_IDLE;
        else if (pv_q == '0)  state_d = ST_DONE;
        else                  state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase

    pv_d[0] = push_valid_s;
    pa_d[0] = push_addr_s;
    for (int i = RAM_LATENCY - 1; i > 0; i--) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
    // An abort discards anything still in flight so no stale compare follows.
    if (abort_s && busy_s) pv_d = '0;
    else                   pv_d = pv_d;

    if (write && !busy_s) begin
      case (address)
        3'd1:    start_addr_d = writedata[ADDR_WIDTH-1:0];
        3'd2:    num_d        = writedata[CW-1:0];
        3'd7:    mask_d       = writedata[DATA_WIDTH-1:0];
        default: start_addr_d = start_addr_q;
      endcase
    end else begin
      start_addr_d = start_addr_q;
    end

    if (read) begin
      case (address)
        3'd0:    readdata_d = {30'd0, busy_s, done_s};
        3'd1:    readdata_d = 32'(start_addr_q);
        3'd2:    readdata_d = 32'(num_q);
        3'd3:    readdata_d = 32'(ID);
        3'd4:    readdata_d = {16'd0, err_pos_q};
        3'd5:    readdata_d = {16'd0, err_neg_q};
        3'd6:    readdata_d = {first_valid_q, first_pos_q, first_neg_q, 29'(first_addr_q)};
        3'd7:    readdata_d = 32'(mask_q);
        default: readdata_d = 32'd0;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge avalon_clock) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      start_addr_q  <= '0;
      num_q         <= '0;
      mask_q        <= '1;
      err_pos_q     <= 16'd0;
      err_neg_q     <= 16'd0;
      first_valid_q <= 1'b0;
      first_pos_q   <= 1'b0;
      first_neg_q   <= 1'b0;
      first_addr_q  <= '0;
      chk_addr_q    <= '0;
      pv_q          <= '0;
      readdata_q    <= 32'd0;
      for (int i = 0; i < RAM_LATENCY; i++) pa_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_addr_q  <= start_addr_d;
      num_q         <= num_d;
      mask_q        <= mask_d;
      err_pos_q     <= err_pos_d;
      err_neg_q     <= err_neg_d;
      first_valid_q <= first_valid_d;
      first_pos_q   <= first_pos_d;
      first_neg_q   <= first_neg_d;
      first_addr_q  <= first_addr_d;
      chk_addr_q    <= chk_addr_d;
      pv_q          <= pv_d;
      readdata_q    <= readdata_d;
      for (int i = 0; i < RAM_LATENCY; i++) pa_q[i] <= pa_d[i];
    end
  end

  assign readdata = readdata_q;
  assign chk_addr = chk_addr_q;

endmodule
